// File: rtl/serial_paralelo_rx.sv
// ---------------------------------------------------------------------------
// serial_paralelo_rx
//
// Receive-side serial-to-parallel converter of the PHY link. Consumes a
// single-bit stream (MSB of each byte first, one bit per clk_32f cycle),
// hunts bit by bit for the 0xBC comma, confirms byte alignment over
// LOCK_COUNT consecutive aligned commas and then delivers data bytes with a
// one-cycle valid strobe. IDLE symbols are flagged on idle_out instead of
// being strobed.
//
// Optional feature (compile-time macro):
//   SERIAL_PARALELO_RX_LOS_EN  -- loss-of-sync detection. Eight consecutive
//                                 0x00/0xFF bytes in ACTIVE drop the link
//                                 back to SEARCH. Undefined: ACTIVE is left
//                                 only by reset.
//
// Parameters:
//   BC          comma / alignment symbol            (default 8'hBC)
//   IDLE        idle symbol                         (default 8'h7C)
//   LOCK_COUNT  aligned commas needed for ACTIVE    (2..7, default 4)
//
// Ports:
//   clk_32f    in   1  serial bit clock, all logic on its rising edge
//   reset      in   1  asynchronous, active-low
//   data_in    in   1  serial bit, MSB of each byte first
//   data_out   out  8  last received data byte
//   valid_out  out  1  one-cycle strobe: data_out holds a new data byte
//   active     out  1  byte alignment locked
//   idle_out   out  1  last non-comma symbol seen in ACTIVE was IDLE
// ---------------------------------------------------------------------------
module serial_paralelo_rx #(
  parameter logic [7:0]  BC         = 8'hBC,
  parameter logic [7:0]  IDLE       = 8'h7C,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active,
  output logic       idle_out
);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_LOCK   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  // Value of bc_cnt at the boundary whose comma completes the lock.
  localparam logic [2:0] LOCK_LAST = 3'(LOCK_COUNT - 1);

  state_t     state, state_n;
  // Only the previous seven bits need storing: together with data_in they
  // form the full byte under test (nxt).
  logic [6:0] shift;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [2:0] bc_cnt, bc_cnt_n;
  logic [7:0] data_n;
  logic       valid_n;
  logic       active_n;
  logic       idle_n;

  logic [7:0] nxt;
  logic       boundary;

  assign nxt      = {shift, data_in};
  assign boundary = (bit_cnt == 3'd7);

`ifdef SERIAL_PARALELO_RX_LOS_EN
  logic [2:0] los_cnt, los_cnt_n;
  logic       stuck;

  assign stuck = (nxt == 8'h00) || (nxt == 8'hFF);
`endif

  // Delivers one ACTIVE-state symbol: commas are transparent, IDLE only
  // raises idle_out, anything else is a data byte.
  function automatic void deliver(input logic [7:0] sym,
                                  inout logic [7:0] d,
                                  inout logic       v,
                                  inout logic       i);
    if (sym == BC) begin
      // Alignment comma: outputs untouched.
    end else if (sym == IDLE) begin
      i = 1'b1;
    end else begin
      d = sym;
      v = 1'b1;
      i = 1'b0;
    end
  endfunction

  // NOTE: every variable this block writes gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt + 3'd1;   // wraps 7 -> 0 freely outside SEARCH
    bc_cnt_n  = bc_cnt;
    data_n    = data_out;
    valid_n   = 1'b0;
    active_n  = active;
    idle_n    = idle_out;
`ifdef SERIAL_PARALELO_RX_LOS_EN
    los_cnt_n = los_cnt;
`endif

    unique case (state)
      ST_SEARCH: begin
        // Bit-level hunt: every edge is a candidate boundary.
        bit_cnt_n = 3'd0;
        active_n  = 1'b0;
        idle_n    = 1'b0;
        if (nxt == BC) begin
          bc_cnt_n = 3'd1;
          state_n  = ST_LOCK;
        end
      end

      ST_LOCK: begin
        if (boundary) begin
          if (nxt == BC) begin
            bc_cnt_n = bc_cnt + 3'd1;
            if (bc_cnt == LOCK_LAST) begin
              state_n  = ST_ACTIVE;
              active_n = 1'b1;
            end
          end else begin
            // A false match on shifted data fails here; the hunt resumes on
            // the very next edge with no dead cycle.
            bc_cnt_n = 3'd0;
            state_n  = ST_SEARCH;
          end
        end
      end

      ST_ACTIVE: begin
        if (boundary) begin
`ifdef SERIAL_PARALELO_RX_LOS_EN
          if (stuck && (los_cnt == 3'd7)) begin
            // Eighth stuck byte in a row: the line is dead, drop the link
            // and swallow this byte.
            state_n   = ST_SEARCH;
            active_n  = 1'b0;
            idle_n    = 1'b0;
            bc_cnt_n  = 3'd0;
            bit_cnt_n = 3'd0;
            los_cnt_n = 3'd0;
          end else begin
            los_cnt_n = stuck ? los_cnt + 3'd1 : 3'd0;
            deliver(nxt, data_n, valid_n, idle_n);
          end
`else
          deliver(nxt, data_n, valid_n, idle_n);
`endif
        end
      end

      default: begin
        state_n   = ST_SEARCH;
        bit_cnt_n = 3'd0;
        bc_cnt_n  = 3'd0;
        active_n  = 1'b0;
        idle_n    = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state     <= ST_SEARCH;
      shift     <= '0;
      bit_cnt   <= '0;
      bc_cnt    <= '0;
      data_out  <= 8'h00;
      valid_out <= 1'b0;
      active    <= 1'b0;
      idle_out  <= 1'b0;
    end else begin
      state     <= state_n;
      shift     <= nxt[6:0];
      bit_cnt   <= bit_cnt_n;
      bc_cnt    <= bc_cnt_n;
      data_out  <= data_n;
      valid_out <= valid_n;
      active    <= active_n;
      idle_out  <= idle_n;
    end
  end

`ifdef SERIAL_PARALELO_RX_LOS_EN
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) los_cnt <= '0;
    else        los_cnt <= los_cnt_n;
  end
`endif

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// ---------------------------------------------------------------------------
// tb_serial_paralelo_rx
//
// Directed self-checking bench for serial_paralelo_rx (default parameters).
// Bits are driven on the falling edge; outputs are sampled 1 time unit after
// each rising edge and a small recorder notes strobes and the active rise.
// Define SERIAL_PARALELO_RX_LOS_EN for both files to exercise loss-of-sync.
// ---------------------------------------------------------------------------
module tb_serial_paralelo_rx;

  localparam logic [7:0] BC_SYM   = 8'hBC;
  localparam logic [7:0] IDLE_SYM = 8'h7C;

  logic       clk_32f = 1'b0;
  logic       reset;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;
  logic       idle_out;

  serial_paralelo_rx dut (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .data_in   (data_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .active    (active),
    .idle_out  (idle_out)
  );

  always #5 clk_32f = ~clk_32f;

  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         n_valid = 0;
  int         last_valid_cyc = -1;
  logic [7:0] last_valid_data = 8'h00;
  int         rise_cyc = -1;
  logic       prev_active = 1'b0;

  task automatic send_bit(input logic b);
    @(negedge clk_32f);
    data_in = b;
    @(posedge clk_32f);
    #1;
    cyc++;
    if (valid_out === 1'b1) begin
      n_valid++;
      last_valid_cyc  = cyc;
      last_valid_data = data_out;
    end
    if (active === 1'b1 && prev_active === 1'b0) rise_cyc = cyc;
    prev_active = active;
  endtask

  task automatic send_bits(input logic [7:0] b, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) send_bit(b[i]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 7, 0);
  endtask

  task automatic apply_reset();
    @(negedge clk_32f);
    reset   = 1'b0;
    data_in = 1'b0;
    repeat (2) @(negedge clk_32f);
    reset = 1'b1;
    prev_active = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if (data_out !== 8'h00) begin
      n_err++; $display("FAIL reset_data_out: got %h want 00", data_out);
    end
    n_cmp++;
    if ({valid_out, active, idle_out} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags: got v/a/i=%b want 000", {valid_out, active, idle_out});
    end
  endtask

  task automatic test_lock_and_data();
    int v0, rc;
    apply_reset();
    v0 = n_valid;
    repeat (3) send_byte(BC_SYM);
    n_cmp++;
    if (active !== 1'b0) begin
      n_err++; $display("FAIL lock_after_3bc: active=%b want 0", active);
    end
    send_bits(BC_SYM, 7, 1);
    n_cmp++;
    if (active !== 1'b0) begin
      n_err++; $display("FAIL lock_before_lsb: active=%b want 0", active);
    end
    send_bit(BC_SYM[0]);
    rc = cyc;
    n_cmp++;
    if (active !== 1'b1 || rise_cyc != rc) begin
      n_err++; $display("FAIL lock_at_lsb: active=%b rise_cyc=%0d want 1 at %0d", active, rise_cyc, rc);
    end
    send_byte(8'h5A);
    n_cmp++;
    if (n_valid - v0 != 1 || last_valid_cyc != rc + 8 || last_valid_data !== 8'h5A) begin
      n_err++; $display("FAIL data_5a: strobes=%0d at %0d data=%h want 1 at %0d data 5a",
                        n_valid - v0, last_valid_cyc, last_valid_data, rc + 8);
    end
    send_byte(8'hC3);
    n_cmp++;
    if (n_valid - v0 != 2 || last_valid_cyc != rc + 16 || last_valid_data !== 8'hC3) begin
      n_err++; $display("FAIL data_c3: strobes=%0d at %0d data=%h want 2 at %0d data c3",
                        n_valid - v0, last_valid_cyc, last_valid_data, rc + 16);
    end
  endtask

  task automatic test_offset();
    int v0, rc;
    apply_reset();
    v0 = n_valid;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    repeat (4) send_byte(BC_SYM);
    rc = cyc;
    n_cmp++;
    if (active !== 1'b1 || rise_cyc != rc) begin
      n_err++; $display("FAIL offset_lock: active=%b rise_cyc=%0d want 1 at %0d", active, rise_cyc, rc);
    end
    send_byte(8'h11);
    n_cmp++;
    if (n_valid - v0 != 1 || last_valid_cyc != rc + 8 || last_valid_data !== 8'h11) begin
      n_err++; $display("FAIL offset_data: strobes=%0d at %0d data=%h want 1 at %0d data 11",
                        n_valid - v0, last_valid_cyc, last_valid_data, rc + 8);
    end
  endtask

  task automatic test_resync();
    int v0;
    apply_reset();
    v0 = n_valid;
    send_byte(BC_SYM); send_byte(BC_SYM); send_byte(8'h12);
    repeat (3) send_byte(BC_SYM);
    n_cmp++;
    if (active !== 1'b0) begin
      n_err++; $display("FAIL resync_no_early_lock: active=%b want 0", active);
    end
    send_byte(BC_SYM);
    n_cmp++;
    if (active !== 1'b1 || rise_cyc != cyc) begin
      n_err++; $display("FAIL resync_lock: active=%b rise_cyc=%0d want 1 at %0d", active, rise_cyc, cyc);
    end
    n_cmp++;
    if (n_valid != v0) begin
      n_err++; $display("FAIL resync_no_strobe: strobes=%0d want 0", n_valid - v0);
    end
  endtask

  task automatic test_idle();
    int v0;
    v0 = n_valid;
    send_byte(8'hA5);
    send_byte(IDLE_SYM);
    n_cmp++;
    if (idle_out !== 1'b1 || n_valid - v0 != 1 || data_out !== 8'hA5) begin
      n_err++; $display("FAIL idle_flag: idle=%b strobes=%0d data=%h want 1/1/a5",
                        idle_out, n_valid - v0, data_out);
    end
    send_byte(BC_SYM);
    n_cmp++;
    if (idle_out !== 1'b1 || n_valid - v0 != 1 || data_out !== 8'hA5) begin
      n_err++; $display("FAIL idle_bc_hold: idle=%b strobes=%0d data=%h want 1/1/a5",
                        idle_out, n_valid - v0, data_out);
    end
    send_byte(8'h33);
    n_cmp++;
    if (idle_out !== 1'b0 || n_valid - v0 != 2 || last_valid_data !== 8'h33 || last_valid_cyc != cyc) begin
      n_err++; $display("FAIL idle_clear: idle=%b strobes=%0d data=%h want 0/2/33",
                        idle_out, n_valid - v0, last_valid_data);
    end
  endtask

  task automatic test_async_reset();
    send_bits(8'h96, 7, 4);
    @(negedge clk_32f);
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({data_out, valid_out, active, idle_out} !== 11'h000) begin
      n_err++; $display("FAIL async_reset: data=%h v/a/i=%b want 00 000",
                        data_out, {valid_out, active, idle_out});
    end
    @(negedge clk_32f);
    reset = 1'b1;
    prev_active = 1'b0;
    repeat (3) send_byte(BC_SYM);
    n_cmp++;
    if (active !== 1'b0) begin
      n_err++; $display("FAIL relock_early: active=%b want 0", active);
    end
    send_byte(BC_SYM);
    n_cmp++;
    if (active !== 1'b1) begin
      n_err++; $display("FAIL relock: active=%b want 1", active);
    end
  endtask

  task automatic test_stuck_line();
    int v0;
    v0 = n_valid;
    repeat (7) send_byte(8'hFF);
    n_cmp++;
    if (n_valid - v0 != 7 || last_valid_data !== 8'hFF || active !== 1'b1) begin
      n_err++; $display("FAIL stuck_first7: strobes=%0d data=%h active=%b want 7/ff/1",
                        n_valid - v0, last_valid_data, active);
    end
    send_byte(8'hFF);
`ifdef SERIAL_PARALELO_RX_LOS_EN
    n_cmp++;
    if (n_valid - v0 != 7 || active !== 1'b0 || idle_out !== 1'b0) begin
      n_err++; $display("FAIL stuck_los: strobes=%0d active=%b idle=%b want 7/0/0",
                        n_valid - v0, active, idle_out);
    end
`else
    n_cmp++;
    if (n_valid - v0 != 8 || active !== 1'b1 || last_valid_cyc != cyc) begin
      n_err++; $display("FAIL stuck_data: strobes=%0d active=%b want 8/1", n_valid - v0, active);
    end
`endif
  endtask

  initial begin
    reset   = 1'b0;
    data_in = 1'b0;
    test_reset();
    test_lock_and_data();
    test_offset();
    test_resync();
    test_idle();
    test_async_reset();
    test_stuck_line();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
